elevator_scheduler: RTL and testbench

- Floor-request scheduler for the elevator system, clocked from the 10 kHz tick domain.
- Latches one-shot floor-call pulses from the debounced/oneshot button path into a pending-request register.
- Picks travel direction using a collective (SCAN) policy, times inter-floor travel and door dwell, and drives motor_onoff/motor_dir toward the step-motor driver.
- Exports current floor, door and state for the FND controller.

---
 rtl/elevator_scheduler.sv | 155 +++++++++++++++
 tb/tb_elevator_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// Collective (SCAN) floor-request scheduler: latches call pulses, picks the
// sweep direction, times floor-to-floor travel and door dwell, and drives the
// step-motor enable/direction plus status outputs for the display.
module elevator_scheduler #(
    parameter int N_FLOORS     = 3,
    parameter int TRAVEL_TICKS = 50000,
    parameter int DOOR_TICKS   = 30000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_FLOORS-1:0] call_tick,
    output logic                motor_onoff,
    output logic                motor_dir,
    output logic [2:0]          cur_floor,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_TICKS - 1);
    localparam logic [15:0] DOOR_LAST   = 16'(DOOR_TICKS - 1);
    localparam logic [2:0]  TOP_FLOOR   = 3'(N_FLOORS - 1);

    state_t              fsm_state;
    logic                dir_up;
    logic [15:0]         travel_timer;
    logic [15:0]         door_timer;

    logic [N_FLOORS-1:0] cur_mask;
    logic [N_FLOORS-1:0] next_mask;
    logic [N_FLOORS-1:0] above_mask;
    logic [N_FLOORS-1:0] below_mask;
    logic [2:0]          next_floor;
    logic                call_here;
    logic                any_above;
    logic                any_below;
    logic                stop_next;

    // Floor masks, the saturated next floor in the sweep direction, and the
    // request summaries the FSM decides on.
    always_comb begin
        cur_mask   = '0;
        next_mask  = '0;
        above_mask = '0;
        below_mask = '0;
        next_floor = cur_floor;
        if (dir_up) begin
            if (cur_floor < TOP_FLOOR) begin
                next_floor = cur_floor + 3'd1;
            end
        end else if (cur_floor != 3'd0) begin
            next_floor = cur_floor - 3'd1;
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            cur_mask[i]   = (i == int'(cur_floor));
            next_mask[i]  = (i == int'(next_floor));
            above_mask[i] = (i > int'(cur_floor));
            below_mask[i] = (i < int'(cur_floor));
        end
        call_here = |(call_tick & cur_mask);
        any_above = |(pending & above_mask);
        any_below = |(pending & below_mask);
        stop_next = |(pending & next_mask);
    end

    // Scheduler FSM with request latch, timers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_state    <= IDLE;
            cur_floor    <= 3'd0;
            pending      <= '0;
            dir_up       <= 1'b1;
            motor_onoff  <= 1'b0;
            motor_dir    <= 1'b1;
            door_open    <= 1'b0;
            travel_timer <= 16'd0;
            door_timer   <= 16'd0;
        end else begin
            case (fsm_state)
                IDLE: begin
                    pending <= pending | (call_tick & ~cur_mask);
                    if (call_here) begin
                        fsm_state  <= DOOR;
                        door_open  <= 1'b1;
                        door_timer <= 16'd0;
                    end else if (dir_up && any_above) begin
                        fsm_state    <= MOVE;
                        motor_onoff  <= 1'b1;
                        motor_dir    <= 1'b1;
                        travel_timer <= 16'd0;
                    end else if (!dir_up && any_below) begin
                        fsm_state    <= MOVE;
                        motor_onoff  <= 1'b1;
                        motor_dir    <= 1'b0;
                        travel_timer <= 16'd0;
                    end else if (any_above) begin
                        fsm_state    <= MOVE;
                        dir_up       <= 1'b1;
                        motor_onoff  <= 1'b1;
                        motor_dir    <= 1'b1;
                        travel_timer <= 16'd0;
                    end else if (any_below) begin
                        fsm_state    <= MOVE;
                        dir_up       <= 1'b0;
                        motor_onoff  <= 1'b1;
                        motor_dir    <= 1'b0;
                        travel_timer <= 16'd0;
                    end
                end
                MOVE: begin
                    pending <= pending | call_tick;
                    if (travel_timer == TRAVEL_LAST) begin
                        travel_timer <= 16'd0;
                        cur_floor    <= next_floor;
                        if (stop_next) begin
                            pending     <= (pending | call_tick) & ~next_mask;
                            fsm_state   <= DOOR;
                            motor_onoff <= 1'b0;
                            door_open   <= 1'b1;
                            door_timer  <= 16'd0;
                        end
                    end else begin
                        travel_timer <= travel_timer + 16'd1;
                    end
                end
                DOOR: begin
                    pending <= pending | (call_tick & ~cur_mask);
                    if (call_here) begin
                        door_timer <= 16'd0;
                    end else if (door_timer == DOOR_LAST) begin
                        door_timer <= 16'd0;
                        door_open  <= 1'b0;
                        fsm_state  <= IDLE;
                    end else begin
                        door_timer <= door_timer + 16'd1;
                    end
                end
                default: begin
                    fsm_state   <= IDLE;
                    motor_onoff <= 1'b0;
                    door_open   <= 1'b0;
                end
            endcase
        end
    end

    assign state = fsm_state;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with short travel/door timings.
module tb_elevator_scheduler;

    logic       clk;
    logic       reset_n;
    logic [2:0] call_tick;
    logic       motor_onoff;
    logic       motor_dir;
    logic [2:0] cur_floor;
    logic       door_open;
    logic [2:0] pending;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    elevator_scheduler #(
        .N_FLOORS    (3),
        .TRAVEL_TICKS(10),
        .DOOR_TICKS  (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .call_tick  (call_tick),
        .motor_onoff(motor_onoff),
        .motor_dir  (motor_dir),
        .cur_floor  (cur_floor),
        .door_open  (door_open),
        .pending    (pending),
        .state      (state)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Floor index must stay in range and the unused state code never appears.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (cur_floor > 3'd2 || state == 2'd3)) begin
            errors++;
            $display("[TB] FAIL range_guard: cur_floor=%0d state=%0d, required floor<=2 and state!=3", cur_floor, state);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Apply a one-cycle call pulse; returns just after the edge that samples it.
    task automatic pulse(input logic [2:0] v);
        call_tick = v;
        step(1);
        call_tick = 3'b000;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        step(1);
        call_tick = 3'b100;
        step(2);
        call_tick = 3'b000;
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rst_state: got %0d required 0", state); end
        checks++; if (cur_floor !== 3'd0) begin errors++; $display("[TB] FAIL rst_floor: got %0d required 0", cur_floor); end
        checks++; if (pending !== 3'b000) begin errors++; $display("[TB] FAIL rst_pending: got %b required 000", pending); end
        checks++; if (motor_onoff !== 1'b0) begin errors++; $display("[TB] FAIL rst_motor: got %b required 0", motor_onoff); end
        checks++; if (motor_dir !== 1'b1) begin errors++; $display("[TB] FAIL rst_dir: got %b required 1", motor_dir); end
        checks++; if (door_open !== 1'b0) begin errors++; $display("[TB] FAIL rst_door: got %b required 0", door_open); end
        reset_n = 1'b1;
        step(3);
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rel_state: got %0d required 0", state); end
        checks++; if (cur_floor !== 3'd0) begin errors++; $display("[TB] FAIL rel_floor: got %0d required 0", cur_floor); end
        checks++; if (pending !== 3'b000) begin errors++; $display("[TB] FAIL rel_pending: got %b required 000", pending); end
    endtask

    task automatic test_own_floor();
        pulse(3'b001);
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL own_state: got %0d required 2", state); end
        checks++; if (door_open !== 1'b1) begin errors++; $display("[TB] FAIL own_door: got %b required 1", door_open); end
        checks++; if (pending !== 3'b000) begin errors++; $display("[TB] FAIL own_pending: got %b required 000", pending); end
        step(1);
        pulse(3'b001);
        step(2);
        checks++; if (door_open !== 1'b1) begin errors++; $display("[TB] FAIL own_restart_mid: got %b required 1", door_open); end
        step(2);
        checks++; if (door_open !== 1'b1) begin errors++; $display("[TB] FAIL own_restart_last: got %b required 1", door_open); end
        step(1);
        checks++; if (door_open !== 1'b0) begin errors++; $display("[TB] FAIL own_close: got %b required 0", door_open); end
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL own_idle: got %0d required 0", state); end
        checks++; if (motor_onoff !== 1'b0) begin errors++; $display("[TB] FAIL own_motor: got %b required 0", motor_onoff); end
        checks++; if (pending !== 3'b000) begin errors++; $display("[TB] FAIL own_pending_end: got %b required 000", pending); end
    endtask

    task automatic test_single_call();
        pulse(3'b100);
        checks++; if (pending !== 3'b100) begin errors++; $display("[TB] FAIL single_pending: got %b required 100", pending); end
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL single_still_idle: got %0d required 0", state); end
        step(1);
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL single_move: got %0d required 1", state); end
        checks++; if (motor_onoff !== 1'b1) begin errors++; $display("[TB] FAIL single_motor: got %b required 1", motor_onoff); end
        checks++; if (motor_dir !== 1'b1) begin errors++; $display("[TB] FAIL single_dir: got %b required 1", motor_dir); end
        step(9);
        checks++; if (cur_floor !== 3'd0) begin errors++; $display("[TB] FAIL single_floor_early: got %0d required 0", cur_floor); end
        step(1);
        checks++; if (cur_floor !== 3'd1) begin errors++; $display("[TB] FAIL single_floor1: got %0d required 1", cur_floor); end
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL single_pass1: got %0d required 1", state); end
        step(10);
        checks++; if (cur_floor !== 3'd2) begin errors++; $display("[TB] FAIL single_floor2: got %0d required 2", cur_floor); end
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL single_door: got %0d required 2", state); end
        checks++; if (pending !== 3'b000) begin errors++; $display("[TB] FAIL single_served: got %b required 000", pending); end
        checks++; if (motor_onoff !== 1'b0) begin errors++; $display("[TB] FAIL single_stop: got %b required 0", motor_onoff); end
        step(4);
        checks++; if (door_open !== 1'b1) begin errors++; $display("[TB] FAIL single_door_last: got %b required 1", door_open); end
        step(1);
        checks++; if (door_open !== 1'b0) begin errors++; $display("[TB] FAIL single_door_close: got %b required 0", door_open); end
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL single_idle: got %0d required 0", state); end
    endtask

    task automatic test_scan_order();
        do_reset();
        pulse(3'b100);
        step(1);
        pulse(3'b001);
        checks++; if (pending !== 3'b101) begin errors++; $display("[TB] FAIL scan_pending: got %b required 101", pending); end
        step(9);
        checks++; if (cur_floor !== 3'd1 || state !== 2'd1) begin errors++; $display("[TB] FAIL scan_pass1: got floor %0d state %0d required floor 1 state 1", cur_floor, state); end
        step(10);
        checks++; if (cur_floor !== 3'd2 || state !== 2'd2) begin errors++; $display("[TB] FAIL scan_first_stop: got floor %0d state %0d required floor 2 state 2", cur_floor, state); end
        checks++; if (pending !== 3'b001) begin errors++; $display("[TB] FAIL scan_left: got %b required 001", pending); end
        step(6);
        checks++; if (state !== 2'd1 || motor_dir !== 1'b0) begin errors++; $display("[TB] FAIL scan_reverse: got state %0d dir %b required state 1 dir 0", state, motor_dir); end
        step(10);
        checks++; if (cur_floor !== 3'd1 || state !== 2'd1) begin errors++; $display("[TB] FAIL scan_pass_down: got floor %0d state %0d required floor 1 state 1", cur_floor, state); end
        step(10);
        checks++; if (cur_floor !== 3'd0 || state !== 2'd2) begin errors++; $display("[TB] FAIL scan_second_stop: got floor %0d state %0d required floor 0 state 2", cur_floor, state); end
        checks++; if (pending !== 3'b000) begin errors++; $display("[TB] FAIL scan_all_served: got %b required 000", pending); end
        step(5);
        checks++; if (dut.dir_up !== 1'b0) begin errors++; $display("[TB] FAIL scan_dir_up: got %b required 0", dut.dir_up); end
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL scan_idle: got %0d required 0", state); end
    endtask

    task automatic test_collision();
        pulse(3'b100);
        step(1);
        checks++; if (state !== 2'd1 || motor_dir !== 1'b1) begin errors++; $display("[TB] FAIL coll_move_up: got state %0d dir %b required state 1 dir 1", state, motor_dir); end
        step(19);
        pulse(3'b100);
        checks++; if (cur_floor !== 3'd2 || state !== 2'd2) begin errors++; $display("[TB] FAIL coll_arrive: got floor %0d state %0d required floor 2 state 2", cur_floor, state); end
        checks++; if (pending !== 3'b000) begin errors++; $display("[TB] FAIL coll_absorbed: got %b required 000", pending); end
        step(8);
        checks++; if (state !== 2'd0 || motor_onoff !== 1'b0 || door_open !== 1'b0) begin errors++; $display("[TB] FAIL coll_one_stop: got state %0d motor %b door %b required 0 0 0", state, motor_onoff, door_open); end
        checks++; if (pending !== 3'b000) begin errors++; $display("[TB] FAIL coll_pending_end: got %b required 000", pending); end
    endtask

    task automatic test_mid_move_reset();
        pulse(3'b001);
        step(5);
        checks++; if (state !== 2'd1 || motor_onoff !== 1'b1) begin errors++; $display("[TB] FAIL mr_moving: got state %0d motor %b required 1 1", state, motor_onoff); end
        reset_n = 1'b0;
        #1;
        checks++; if (motor_onoff !== 1'b0) begin errors++; $display("[TB] FAIL mr_motor_async: got %b required 0", motor_onoff); end
        checks++; if (cur_floor !== 3'd0) begin errors++; $display("[TB] FAIL mr_floor: got %0d required 0", cur_floor); end
        checks++; if (pending !== 3'b000) begin errors++; $display("[TB] FAIL mr_pending: got %b required 000", pending); end
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL mr_state: got %0d required 0", state); end
        step(1);
        reset_n = 1'b1;
        step(25);
        checks++; if (state !== 2'd0 || motor_onoff !== 1'b0 || cur_floor !== 3'd0) begin errors++; $display("[TB] FAIL mr_no_motion: got state %0d motor %b floor %0d required 0 0 0", state, motor_onoff, cur_floor); end
    endtask

    // Run all scenarios in order and print the summary.
    initial begin
        reset_n   = 1'b0;
        call_tick = 3'b000;
        test_reset();
        test_own_floor();
        test_single_call();
        test_scan_order();
        test_collision();
        do_reset();
        pulse(3'b100);
        step(30);
        test_mid_move_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
